// File: rtl/fetch_stage.sv
// IF stage: one-outstanding imem fetch, small fetch buffer, IF/ID register.
// Redirect (PCSF) reloads the PC, flushes buffer and IF/ID, and discards any in-flight response.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          FB_DEPTH  = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSF,
  input  logic [63:0] PCTargetD,
  input  logic        StallD,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [63:0] PCD,
  output logic [63:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_t;

  localparam int             AW      = $clog2(FB_DEPTH);
  localparam int             CW      = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FB_DEPTH);

  state_t         r_state, w_state_n;
  logic [63:0]    r_pc, w_pc_n;
  logic [63:0]    r_req_pc, w_req_pc_n;
  logic           r_req;
  logic [AW-1:0]  r_rd_ptr, r_wr_ptr, w_rd_ptr_n, w_wr_ptr_n;
  logic [CW-1:0]  r_count, w_count_n;
  logic [31:0]    r_fb_instr [FB_DEPTH];
  logic [63:0]    r_fb_pc    [FB_DEPTH];
  logic [31:0]    r_instr_d;
  logic [63:0]    r_pc_d, r_pc4_d;
  logic           r_valid_d;
  logic           w_gnt, w_push, w_pop;

  // A grant only counts while our registered request is actually up.
  assign w_gnt = r_req & imem_gnt;
  assign w_pop = !PCSF && !StallD && (r_count != '0);

  always_comb begin
    w_state_n  = r_state;
    w_pc_n     = r_pc;
    w_req_pc_n = r_req_pc;
    w_push     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_gnt) begin
          w_req_pc_n = r_pc;
          if (PCSF) begin
            w_state_n = S_DRAIN;
            w_pc_n    = PCTargetD;
          end else begin
            w_state_n = S_WAIT;
            w_pc_n    = r_pc + 64'd4;
          end
        end else if (PCSF) begin
          w_pc_n = PCTargetD;
        end
      end
      S_WAIT: begin
        if (PCSF) begin
          w_pc_n    = PCTargetD;
          w_state_n = imem_rvalid ? S_FETCH : S_DRAIN;
        end else if (imem_rvalid) begin
          w_push    = 1'b1;
          w_state_n = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (PCSF) w_pc_n = PCTargetD;
        if (imem_rvalid) w_state_n = S_FETCH;
      end
      default: w_state_n = S_FETCH;
    endcase
  end

  always_comb begin
    w_rd_ptr_n = r_rd_ptr;
    w_wr_ptr_n = r_wr_ptr;
    w_count_n  = r_count;
    if (PCSF) begin
      w_rd_ptr_n = '0;
      w_wr_ptr_n = '0;
      w_count_n  = '0;
    end else begin
      if (w_push) w_wr_ptr_n = r_wr_ptr + AW'(1);
      if (w_pop)  w_rd_ptr_n = r_rd_ptr + AW'(1);
      w_count_n = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_req    <= 1'b0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_pc     <= w_pc_n;
      r_req_pc <= w_req_pc_n;
      // Request decided from next-cycle state so it is a clean register output.
      r_req    <= (w_state_n == S_FETCH) && (w_count_n < DEPTH_C);
      r_rd_ptr <= w_rd_ptr_n;
      r_wr_ptr <= w_wr_ptr_n;
      r_count  <= w_count_n;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fb_instr[r_wr_ptr] <= imem_rdata;
      r_fb_pc[r_wr_ptr]    <= r_req_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= '0;
      r_pc4_d   <= '0;
      r_valid_d <= 1'b0;
    end else if (PCSF) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= '0;
      r_pc4_d   <= '0;
      r_valid_d <= 1'b0;
    end else if (!StallD) begin
      if (r_count != '0) begin
        r_instr_d <= r_fb_instr[r_rd_ptr];
        r_pc_d    <= r_fb_pc[r_rd_ptr];
        r_pc4_d   <= r_fb_pc[r_rd_ptr] + 64'd4;
        r_valid_d <= 1'b1;
      end else begin
        r_instr_d <= NOP_INSTR;
        r_pc_d    <= '0;
        r_pc4_d   <= '0;
        r_valid_d <= 1'b0;
      end
    end
  end

  // The slot is reserved at grant time, so a push into a full buffer is a design error.
  assert property (@(posedge clk) disable iff (rst) !(w_push && (r_count == DEPTH_C)));

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign InstrD    = r_instr_d;
  assign PCD       = r_pc_d;
  assign PCPlus4D  = r_pc4_d;
  assign ValidD    = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a queue-based reference model.
module tb_fetch_stage;
  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam int          FB_DEPTH  = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [63:0] WRAP_PC   = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSF = 1'b0;
  logic [63:0] PCTargetD = '0;
  logic        StallD = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] InstrD;
  logic [63:0] PCD, PCPlus4D;
  logic        ValidD;

  fetch_stage #(.RESET_PC(RESET_PC), .FB_DEPTH(FB_DEPTH), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .PCSF(PCSF), .PCTargetD(PCTargetD), .StallD(StallD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus controls
  logic        c_pcsf = 1'b0;
  logic [63:0] c_target = '0;
  logic        c_stall = 1'b0;
  int          c_gnt_pct = 100;
  int          c_lat_min = 0;
  int          c_lat_max = 0;
  logic        force_gnt = 1'b0;

  // Reference model: fetch PC, the single outstanding access, decoded-word queue, expected outputs
  ent_t        q[$];
  logic [63:0] m_fetch_pc;
  logic        m_out, m_live;
  int          m_lat;
  logic [63:0] m_addr;
  logic        e_req, e_valid;
  logic [31:0] e_instr;
  logic [63:0] e_pc, e_pc4;
  logic        seen_wrap = 1'b0;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0003;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fetch_pc = RESET_PC;
    m_out = 1'b0; m_live = 1'b0; m_lat = 0; m_addr = '0;
    e_req = 1'b0; e_valid = 1'b0; e_instr = NOP_INSTR; e_pc = '0; e_pc4 = '0;
  endtask

  task automatic check_outputs();
    chk("imem_req", {63'd0, imem_req}, {63'd0, e_req});
    if (e_req) chk("imem_addr", imem_addr, m_fetch_pc);
    chk("ValidD", {63'd0, ValidD}, {63'd0, e_valid});
    chk("InstrD", {32'd0, InstrD}, {32'd0, e_instr});
    chk("PCD", PCD, e_pc);
    chk("PCPlus4D", PCPlus4D, e_pc4);
    if (ValidD && PCD == WRAP_PC) seen_wrap = 1'b1;
  endtask

  task automatic drive_and_update();
    logic gnt, rv, granted, push;
    ent_t e;
    gnt = force_gnt || ($urandom_range(99) < c_gnt_pct);
    rv  = m_out && (m_lat == 0);
    PCSF        = c_pcsf;
    PCTargetD   = c_target;
    StallD      = c_stall;
    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_rdata  = rv ? word_at(m_addr) : $urandom();

    granted = e_req && gnt;
    push    = rv && m_live && !c_pcsf;
    if (c_pcsf) begin
      q.delete();
      e_valid = 1'b0; e_instr = NOP_INSTR; e_pc = '0; e_pc4 = '0;
    end else begin
      if (!c_stall) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          e_valid = 1'b1; e_instr = e.instr; e_pc = e.pc; e_pc4 = e.pc + 64'd4;
        end else begin
          e_valid = 1'b0; e_instr = NOP_INSTR; e_pc = '0; e_pc4 = '0;
        end
      end
      if (push) begin
        e.instr = word_at(m_addr);
        e.pc    = m_addr;
        q.push_back(e);
      end
    end
    if (granted) begin
      m_out  = 1'b1;
      m_live = !c_pcsf;
      m_addr = m_fetch_pc;
      m_lat  = $urandom_range(c_lat_max, c_lat_min);
    end else if (rv) begin
      m_out = 1'b0;
    end else if (m_out) begin
      m_lat--;
      if (c_pcsf) m_live = 1'b0;
    end
    if (c_pcsf) m_fetch_pc = c_target;
    else if (granted) m_fetch_pc = m_fetch_pc + 64'd4;
    e_req = !m_out && (q.size() < FB_DEPTH);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs();
      drive_and_update();
    end
  endtask

  task automatic idle_ctl();
    c_pcsf = 1'b0; c_stall = 1'b0; force_gnt = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    idle_ctl();
    drive_and_update();
  endtask

  // kind 0: in WAIT before the response; 1: with a grant; 2: with the response; 3: with a full buffer
  task automatic redirect_when(input int kind, input logic [63:0] tgt, input string tag);
    logic hit, cond;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      check_outputs();
      case (kind)
        0:       cond = m_out && m_live && (m_lat > 0);
        1:       cond = e_req;
        2:       cond = m_out && m_live && (m_lat == 0);
        default: cond = (q.size() == FB_DEPTH);
      endcase
      if (cond) begin
        c_pcsf = 1'b1; c_target = tgt; hit = 1'b1;
        if (kind == 1) force_gnt = 1'b1;
      end
      drive_and_update();
      c_pcsf = 1'b0; force_gnt = 1'b0;
    end
    chk(tag, {63'd0, hit}, 64'd1);
  endtask

  initial begin
    logic [63:0] t;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end

    // 1: straight-line fetch, grant immediately, response one cycle later
    c_gnt_pct = 100; c_lat_min = 0; c_lat_max = 0;
    release_reset();
    step(12);

    // 2: decode stall for five cycles fills the buffer and blocks requests
    c_stall = 1'b1;
    step(5);
    chk("req_low_when_full", {63'd0, imem_req}, 64'd0);
    c_stall = 1'b0;
    step(10);

    // 3: redirect while waiting on a slow response
    c_lat_min = 2; c_lat_max = 2;
    redirect_when(0, 64'h100, "redir_in_wait");
    step(12);

    // 4: redirect coincident with grant, then with response
    c_lat_min = 0; c_lat_max = 1; c_gnt_pct = 60;
    redirect_when(1, 64'h400, "redir_with_gnt");
    step(10);
    redirect_when(2, 64'h800, "redir_with_rvalid");
    step(10);

    // 5: redirect and stall together on a full buffer
    c_gnt_pct = 100; c_lat_min = 0; c_lat_max = 0;
    c_stall = 1'b1;
    redirect_when(3, 64'h2000, "redir_full_stall");
    c_stall = 1'b0;
    step(10);

    // 6: asynchronous reset mid-WAIT, then wrap-around fetch
    c_lat_min = 3; c_lat_max = 3;
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
        step(1);
        hit = m_out && m_live && (m_lat > 0);
      end
      chk("reached_wait", {63'd0, hit}, 64'd1);
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {63'd0, imem_req}, 64'd0);
    chk("arst_valid", {63'd0, ValidD}, 64'd0);
    chk("arst_instr", {32'd0, InstrD}, {32'd0, NOP_INSTR});
    chk("arst_pcd", PCD, 64'd0);
    chk("arst_pc4", PCPlus4D, 64'd0);
    model_reset();
    idle_ctl();
    PCSF = 1'b0; StallD = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    c_lat_min = 0; c_lat_max = 0;
    release_reset();
    @(negedge clk);
    check_outputs();
    chk("post_rst_addr", imem_addr, RESET_PC);
    c_pcsf = 1'b1; c_target = WRAP_PC;
    drive_and_update();
    c_pcsf = 1'b0;
    step(8);
    chk("wrap_seen", {63'd0, seen_wrap}, 64'd1);

    // Random traffic
    c_lat_min = 0; c_lat_max = 3; c_gnt_pct = 70;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      check_outputs();
      c_stall = ($urandom_range(99) < 20);
      c_pcsf  = ($urandom_range(99) < 5);
      t = {$urandom(), $urandom()};
      t[1:0] = 2'b00;
      if ($urandom_range(9) == 0) t = WRAP_PC - 64'(4 * $urandom_range(3));
      c_target = t;
      drive_and_update();
    end
    idle_ctl();
    step(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
